// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO with valid/ready back-pressure
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_valid,
    output logic       uart_ready,
    input  logic [7:0] uart_data,
    output logic       tx,
    output logic       busy
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [CW-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n, push, pop, tick, have;

    // ready comes only from the registered count so it never combinationally follows uart_valid
    assign uart_ready = count != FULL;
    assign push       = uart_valid && uart_ready;
    assign have       = count != '0;
    assign tick       = baud_cnt == LAST;
    assign busy       = (state != IDLE) || have;

    always_comb begin
        state_n    = state;
        baud_cnt_n = tick ? '0 : baud_cnt + 1'b1;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        tx_n       = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                tx_n       = !have;
                pop        = have;
                shift_n    = have ? mem[rd_ptr] : shift;
                state_n    = have ? START : IDLE;
            end
            START: if (tick) begin
                tx_n      = shift[0];
                bit_idx_n = '0;
                state_n   = DATA;
            end
            DATA: if (tick) begin
                tx_n      = (bit_idx == 3'd7) ? 1'b1 : shift[1];
                shift_n   = (bit_idx == 3'd7) ? shift : shift >> 1;
                bit_idx_n = (bit_idx == 3'd7) ? bit_idx : bit_idx + 1'b1;
                state_n   = (bit_idx == 3'd7) ? STOP : DATA;
            end
            STOP: if (tick) begin
                // chain straight into the next start bit when more bytes are waiting
                tx_n    = !have;
                pop     = have;
                shift_n = have ? mem[rd_ptr] : shift;
                state_n = have ? START : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            tx       <= tx_n;
            count    <= count + (AW + 1)'(push) - (AW + 1)'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= uart_data;
    end
endmodule
